// File: rtl/jtvigil_tile_romrd.sv
// Tile ROM responder: caches fetched 32-bit rows (two 16-bit SDRAM beats) per layer address.
// Optional macro JTVIGIL_ROMRD_CACHE2_EN selects a two-entry LRU cache instead of one entry.
module jtvigil_tile_romrd #(
  parameter int          AW     = 17,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] BEAT0 = 2'd2;
  localparam logic [1:0] BEAT1 = 2'd3;

  logic [1:0]    state;
  logic [AW-2:0] cur;
  logic [AW-2:0] target;
  logic [15:0]   low;
  logic [21:0]   req_addr;
  logic          beat;
  logic          fill;
  logic          hit;
  logic          unused_bit0;

  assign cur         = rom_addr[AW-1:1];
  assign unused_bit0 = rom_addr[0];
  assign req_addr    = OFFSET + {{(22-AW){1'b0}}, cur, 1'b0};
  assign beat        = data_dst & data_rdy;
  assign fill        = (state == BEAT1) & beat;
  assign rom_ok      = rom_cs & hit;

  // A fetch always completes under the latched target, even if rom_addr moves away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      target     <= '0;
      low        <= '0;
    end else begin
      case (state)
        IDLE: if (rom_cs && !hit) begin
          target     <= cur;
          sdram_addr <= req_addr;
          sdram_req  <= 1'b1;
          state      <= REQ;
        end
        REQ: if (sdram_ack) begin
          sdram_req <= 1'b0;
          state     <= BEAT0;
        end
        BEAT0: if (beat) begin
          low   <= data_read;
          state <= BEAT1;
        end
        BEAT1: if (beat) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JTVIGIL_ROMRD_CACHE2_EN
  logic [1:0]           valid;
  logic [1:0][AW-2:0]   tags;
  logic [1:0][31:0]     rows;
  logic                 lru;
  logic                 hit0;
  logic                 hit1;

  assign hit0     = valid[0] & (tags[0] == cur);
  assign hit1     = valid[1] & (tags[1] == cur);
  assign hit      = hit0 | hit1;
  assign rom_data = hit1 ? rows[1] : rows[0];

  // lru names the entry to replace next; a hit points it at the other entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      tags  <= '0;
      rows  <= '0;
      lru   <= 1'b0;
    end else if (fill) begin
      valid[lru] <= 1'b1;
      tags[lru]  <= target;
      rows[lru]  <= {data_read, low};
      lru        <= ~lru;
    end else if (rom_cs && hit) begin
      lru <= hit0;
    end
  end
`else
  logic          valid;
  logic [AW-2:0] tag;
  logic [31:0]   row;

  assign hit      = valid & (tag == cur);
  assign rom_data = row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      row   <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= target;
      row   <= {data_read, low};
    end
  end
`endif

endmodule
